systolic_skew_feeder: RTL and testbench



---
 rtl/systolic_skew_feeder_pkg.sv | 17 +
 rtl/skew_delay_line.sv | 25 ++
 rtl/systolic_skew_feeder.sv | 150 +++++++++++++++
 tb/tb_systolic_skew_feeder.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_skew_feeder_pkg.sv
// Shared defaults, accumulator width and FSM state encoding for the systolic skew feeder.
// Pure declarations; no timing or flow-control behaviour of its own.
package systolic_pkg;
    localparam int DEF_DATAWIDTH = 8;
    localparam int DEF_N_SIZE    = 2;
    localparam int DEF_MAX_ROWS  = 16;
    localparam int ACCW          = 3 * DEF_DATAWIDTH;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_WT,
        WT_GAP,
        STREAM,
        FLUSH,
        DONE
    } feeder_state_t;
endpackage

// File: rtl/skew_delay_line.sv
// Per-lane skew chain of DEPTH registers that shift only when adv is high.
// Latency: DEPTH advance steps; contents freeze while adv is low.
module skew_delay_line #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             adv,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < DEPTH; s++) stage[s] <= '0;
        end else if (adv) begin
            stage[0] <= d;
            for (int s = 1; s < DEPTH; s++) stage[s] <= stage[s-1];
        end
    end

    assign q = stage[DEPTH-1];
endmodule

// File: rtl/systolic_skew_feeder.sv
// Loads one weight tile into the systolic array, then streams skewed A rows plus N_SIZE-1 zero flush steps.
// Latency: weight strobe 1 cycle after accept, first sa_valid >= 3 cycles after accept; lane i lags i steps.
// Backpressure: wt_ready only in IDLE, a_ready only in STREAM; SYSTOLIC_FEEDER_PSUM_EN adds skewed psum lanes.
module systolic_skew_feeder
    import systolic_pkg::*;
#(
    parameter int DATAWIDTH = DEF_DATAWIDTH,
    parameter int N_SIZE    = DEF_N_SIZE,
    parameter int MAX_ROWS  = DEF_MAX_ROWS
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                wt_valid,
    output logic                                wt_ready,
    input  logic [DATAWIDTH*N_SIZE*N_SIZE-1:0]  wt_tile,
    input  logic [$clog2(MAX_ROWS+1)-1:0]       tile_rows,
    input  logic                                a_valid,
    output logic                                a_ready,
    input  logic [DATAWIDTH*N_SIZE-1:0]         a_row,
`ifdef SYSTOLIC_FEEDER_PSUM_EN
    input  logic [3*DATAWIDTH*N_SIZE-1:0]       psum_row,
`endif
    output logic                                sa_wt_en,
    output logic [DATAWIDTH*N_SIZE*N_SIZE-1:0]  sa_wt_flat,
    output logic                                sa_valid,
    output logic [DATAWIDTH*N_SIZE-1:0]         sa_matrix_A,
    output logic [3*DATAWIDTH*N_SIZE-1:0]       sa_matrix_B,
    output logic                                tile_done,
    output logic                                busy
);
    localparam int RW = $clog2(MAX_ROWS + 1);
    localparam int FW = (N_SIZE > 2) ? $clog2(N_SIZE) : 1;
    localparam logic [FW-1:0] FLUSH_LAST = FW'((N_SIZE > 1) ? N_SIZE - 2 : 0);

    feeder_state_t             state;
    logic [RW-1:0]             rows_lat;
    logic [RW-1:0]             row_cnt;
    logic [FW-1:0]             flush_cnt;
    logic                      adv;
    logic [DATAWIDTH*N_SIZE-1:0] a_in;

    assign wt_ready = (state == IDLE);
    assign a_ready  = (state == STREAM);
    // One advance step per accepted row, and unconditionally during the flush.
    assign adv      = (a_valid && a_ready) || (state == FLUSH);
    assign a_in     = (state == FLUSH) ? '0 : a_row;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sa_wt_en   <= 1'b0;
            sa_wt_flat <= '0;
            tile_done  <= 1'b0;
            busy       <= 1'b0;
            rows_lat   <= '0;
            row_cnt    <= '0;
            flush_cnt  <= '0;
        end else begin
            sa_wt_en  <= 1'b0;
            tile_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (wt_valid) begin
                        sa_wt_flat <= wt_tile;
                        rows_lat   <= tile_rows;
                        sa_wt_en   <= 1'b1;
                        busy       <= 1'b1;
                        state      <= LOAD_WT;
                    end
                end
                LOAD_WT: state <= WT_GAP;
                WT_GAP: begin
                    row_cnt   <= '0;
                    flush_cnt <= '0;
                    if (rows_lat == '0) begin
                        tile_done <= 1'b1;
                        state     <= DONE;
                    end else begin
                        state <= STREAM;
                    end
                end
                STREAM: begin
                    if (a_valid) begin
                        row_cnt <= row_cnt + 1'b1;
                        if (row_cnt == rows_lat - 1'b1) begin
                            if (N_SIZE > 1) begin
                                state <= FLUSH;
                            end else begin
                                tile_done <= 1'b1;
                                state     <= DONE;
                            end
                        end
                    end
                end
                FLUSH: begin
                    flush_cnt <= flush_cnt + 1'b1;
                    if (flush_cnt == FLUSH_LAST) begin
                        tile_done <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sa_valid <= 1'b0;
        else        sa_valid <= adv;
    end

    for (genvar i = 0; i < N_SIZE; i++) begin : g_a_lane
        skew_delay_line #(
            .WIDTH (DATAWIDTH),
            .DEPTH (i + 1)
        ) u_a_dly (
            .clk   (clk),
            .rst_n (rst_n),
            .adv   (adv),
            .d     (a_in[i*DATAWIDTH +: DATAWIDTH]),
            .q     (sa_matrix_A[i*DATAWIDTH +: DATAWIDTH])
        );
    end

`ifdef SYSTOLIC_FEEDER_PSUM_EN
    localparam int AW = 3 * DATAWIDTH;
    logic [AW*N_SIZE-1:0] b_in;

    assign b_in = (state == FLUSH) ? '0 : psum_row;

    for (genvar j = 0; j < N_SIZE; j++) begin : g_b_lane
        skew_delay_line #(
            .WIDTH (AW),
            .DEPTH (j + 1)
        ) u_b_dly (
            .clk   (clk),
            .rst_n (rst_n),
            .adv   (adv),
            .d     (b_in[j*AW +: AW]),
            .q     (sa_matrix_B[j*AW +: AW])
        );
    end
`else
    assign sa_matrix_B = '0;
`endif
endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed and randomized tiles for systolic_skew_feeder, checked against a row-index skew model.
// Drives and samples on the falling clock edge so the DUT sees stable inputs at each rising edge.
module tb_systolic_skew_feeder;
    import systolic_pkg::*;

    localparam int DW   = 8;
    localparam int N    = 2;
    localparam int MAXR = 16;
    localparam int AW   = ACCW;
    localparam int RW   = $clog2(MAXR + 1);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                wt_valid, wt_ready;
    logic [DW*N*N-1:0]   wt_tile;
    logic [RW-1:0]       tile_rows;
    logic                a_valid, a_ready;
    logic [DW*N-1:0]     a_row;
    logic                sa_wt_en, sa_valid, tile_done, busy;
    logic [DW*N*N-1:0]   sa_wt_flat;
    logic [DW*N-1:0]     sa_matrix_A;
    logic [AW*N-1:0]     sa_matrix_B;
`ifdef SYSTOLIC_FEEDER_PSUM_EN
    logic [AW*N-1:0]     psum_row;
    logic [AW-1:0]       p_m [MAXR][N];
`endif

    logic [DW-1:0] a_m [MAXR][N];
    int cur_rows;
    int n_total = 0;
    int n_bad   = 0;

    systolic_skew_feeder #(.DATAWIDTH(DW), .N_SIZE(N), .MAX_ROWS(MAXR)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wt_valid    (wt_valid),
        .wt_ready    (wt_ready),
        .wt_tile     (wt_tile),
        .tile_rows   (tile_rows),
        .a_valid     (a_valid),
        .a_ready     (a_ready),
        .a_row       (a_row),
`ifdef SYSTOLIC_FEEDER_PSUM_EN
        .psum_row    (psum_row),
`endif
        .sa_wt_en    (sa_wt_en),
        .sa_wt_flat  (sa_wt_flat),
        .sa_valid    (sa_valid),
        .sa_matrix_A (sa_matrix_A),
        .sa_matrix_B (sa_matrix_B),
        .tile_done   (tile_done),
        .busy        (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW*N*N-1:0] w4(input int e0, input int e1, input int e2, input int e3);
        return {DW'(e3), DW'(e2), DW'(e1), DW'(e0)};
    endfunction

    // After advance step k, lane i shows row (k-1-i) element i, or zero outside the tile.
    function automatic logic [DW*N-1:0] exp_a(input int k);
        logic [DW*N-1:0] v = '0;
        for (int i = 0; i < N; i++) begin
            int r = k - 1 - i;
            if (r >= 0 && r < cur_rows) v[i*DW +: DW] = a_m[r][i];
        end
        return v;
    endfunction

`ifdef SYSTOLIC_FEEDER_PSUM_EN
    function automatic logic [AW*N-1:0] exp_b(input int k);
        logic [AW*N-1:0] v = '0;
        for (int j = 0; j < N; j++) begin
            int r = k - 1 - j;
            if (r >= 0 && r < cur_rows) v[j*AW +: AW] = p_m[r][j];
        end
        return v;
    endfunction
`endif

    task automatic fill_rand(input int r_cnt);
        for (int r = 0; r < r_cnt; r++) begin
            for (int i = 0; i < N; i++) begin
                a_m[r][i] = DW'($urandom_range(1, 255));
`ifdef SYSTOLIC_FEEDER_PSUM_EN
                p_m[r][i] = AW'($urandom_range(1, 100000));
`endif
            end
        end
    endtask

    task automatic drive_a(input int nrow, input int r_cnt);
        logic [63:0] rnd;
        rnd = {$urandom, $urandom};
        a_valid = 1'b1;
        if (nrow < r_cnt) begin
            for (int i = 0; i < N; i++) a_row[i*DW +: DW] = a_m[nrow][i];
        end else begin
            a_row = rnd[DW*N-1:0];
        end
`ifdef SYSTOLIC_FEEDER_PSUM_EN
        if (nrow < r_cnt) begin
            for (int j = 0; j < N; j++) psum_row[j*AW +: AW] = p_m[nrow][j];
        end else begin
            psum_row = rnd[AW*N-1:0];
        end
`endif
    endtask

    task automatic chk_cleared(input string pfx);
        chk({pfx, "_wt_en"}, sa_wt_en, 0);
        chk({pfx, "_valid"}, sa_valid, 0);
        chk({pfx, "_done"}, tile_done, 0);
        chk({pfx, "_busy"}, busy, 0);
        chk({pfx, "_flat"}, sa_wt_flat, 0);
        chk({pfx, "_lane_a"}, sa_matrix_A, 0);
        chk({pfx, "_lane_b"}, sa_matrix_B, 0);
        chk({pfx, "_a_ready"}, a_ready, 0);
    endtask

    // Entered and left at a falling edge with the DUT in IDLE.
    task automatic run_tile(input logic [DW*N*N-1:0] w, input int r_cnt, input int bub_after,
                            input bit rnd_gaps, input bit offer_next,
                            input logic [DW*N*N-1:0] next_w, input int next_r, input bit abort);
        int cyc, k, nrow, hold, exp_valids;
        bit acc, done;
        exp_valids = (r_cnt > 0) ? r_cnt + N - 1 : 0;
        cur_rows = r_cnt;
        chk("accept_wt_ready", wt_ready, 1);
        wt_valid = 1'b1; wt_tile = w; tile_rows = RW'(r_cnt); a_valid = 1'b0;
        @(negedge clk);
        chk("wt_en_pulse", sa_wt_en, 1);
        chk("wt_flat", sa_wt_flat, w);
        chk("busy_load", busy, 1);
        wt_valid  = offer_next;
        wt_tile   = offer_next ? next_w : DW*N*N'($urandom);
        tile_rows = offer_next ? RW'(next_r) : RW'($urandom_range(0, MAXR));
        cyc = 1; k = 0; nrow = 0; hold = 0; done = 0;
        drive_a(nrow, r_cnt);
        acc = a_valid && a_ready;
        while (!done && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (acc) begin
                nrow++;
                if (nrow == bub_after) hold = 2;
                else if (rnd_gaps) hold = $urandom_range(0, 2);
            end
            chk("wt_en_single", sa_wt_en, 0);
            if (offer_next) chk("wt_ready_busy", wt_ready, 0);
            if (cyc == 2) chk("gap_a_ready", a_ready, 0);
            if (cyc == 3) chk("stream_a_ready", a_ready, r_cnt > 0);
            if (sa_valid) begin
                if (k >= exp_valids) begin
                    chk("extra_valid", sa_valid, 0);
                end else begin
                    k++;
                    chk("lane_a", sa_matrix_A, exp_a(k));
`ifdef SYSTOLIC_FEEDER_PSUM_EN
                    chk("lane_b", sa_matrix_B, exp_b(k));
`else
                    chk("lane_b_zero", sa_matrix_B, 0);
`endif
                end
            end else if (k > 0) begin
                chk("hold_a", sa_matrix_A, exp_a(k));
            end
            if (tile_done) begin
                done = 1;
                chk("valid_total", k, exp_valids);
                chk("wt_flat_hold", sa_wt_flat, w);
                if (r_cnt == 0) chk("done_latency", cyc, 3);
            end else if (abort && k == r_cnt && k > 0) begin
                #2 rst_n = 1'b0;
                #1;
                chk_cleared("abort");
                chk("abort_wt_ready", wt_ready, 1);
                wt_valid = 1'b0; a_valid = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                done = 1;
            end else begin
                if (hold > 0) begin
                    a_valid = 1'b0;
                    hold--;
                end else begin
                    drive_a(nrow, r_cnt);
                end
                acc = a_valid && a_ready;
            end
        end
        if (!done) chk("done_timeout", tile_done, 1);
        a_valid = 1'b0;
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_done", tile_done, 0);
        chk("idle_wt_ready", wt_ready, 1);
    endtask

    initial begin
        wt_valid = 1'b0; wt_tile = '0; tile_rows = '0;
        a_valid = 1'b0; a_row = '0;
`ifdef SYSTOLIC_FEEDER_PSUM_EN
        psum_row = '0;
`endif
        repeat (2) @(negedge clk);
        chk_cleared("reset");
        chk("reset_wt_ready", wt_ready, 1);
        rst_n = 1'b1;
        @(negedge clk);

        // Plan rows {1,2},{5,6},{9,10},{13,14}: continuous, then with a 2-cycle bubble after row 2.
        for (int r = 0; r < 4; r++) begin
            a_m[r][0] = DW'(4*r + 1);
            a_m[r][1] = DW'(4*r + 2);
        end
        run_tile(w4(1, 2, 5, 6), 4, -1, 0, 0, '0, 0, 0);
        run_tile(w4(1, 2, 5, 6), 4, 2, 0, 0, '0, 0, 0);

        // Back-to-back: second tile offered throughout the first.
        fill_rand(5);
        run_tile(w4(9, 10, 13, 14), 5, -1, 0, 1, w4(3, 4, 7, 8), 3, 0);
        fill_rand(3);
        run_tile(w4(3, 4, 7, 8), 3, -1, 0, 0, '0, 0, 0);

        run_tile(w4(11, 22, 33, 44), 0, -1, 0, 0, '0, 0, 0);
        fill_rand(MAXR);
        run_tile(DW*N*N'($urandom), MAXR, -1, 0, 0, '0, 0, 0);

        for (int t = 0; t < 5; t++) begin
            int r;
            r = $urandom_range(1, MAXR);
            fill_rand(r);
            run_tile(DW*N*N'($urandom), r, -1, 1, 0, '0, 0, 0);
        end

        fill_rand(3);
        run_tile(w4(5, 6, 7, 8), 3, -1, 0, 0, '0, 0, 1);
        fill_rand(4);
        run_tile(w4(8, 7, 6, 5), 4, -1, 0, 0, '0, 0, 0);

        fill_rand(2);
`ifdef SYSTOLIC_FEEDER_PSUM_EN
        p_m[0][0] = AW'(90);  p_m[0][1] = AW'(100);
        p_m[1][0] = AW'(202); p_m[1][1] = AW'(228);
`endif
        run_tile(w4(1, 1, 1, 1), 2, -1, 0, 0, '0, 0, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
